serial_subtractor: RTL

Bit-serial unsigned subtractor. Computes `a - b - borrowIn` LSB-first, one bit per clock, through a single full-subtractor cell. It is the inverse-direction counterpart of the team's full-adder arithmetic: the carry chain becomes a registered borrow chain. It sits beside the adder cells in the datapath library and serves area-constrained paths that can tolerate WIDTH-cycle latency, behind a start/done handshake.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic cells.
// Holds the FSM state encoding and the bit-counter sizing rule.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must reach WIDTH, so it needs clog2(WIDTH+1) bits, never fewer than one.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: difference = a - b - borrowIn, with borrow out.
// Purely combinational, gate-level like the matching full-adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrowIn,
    output logic difference,
    output logic borrowOut
);

    logic w_a_xor_b;
    logic w_b_over_a;
    logic w_pass_borrow;

    assign w_a_xor_b     = a ^ b;
    assign w_b_over_a    = ~a & b;
    assign w_pass_borrow = ~w_a_xor_b & borrowIn;

    assign difference = w_a_xor_b ^ borrowIn;
    assign borrowOut  = w_b_over_a | w_pass_borrow;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - borrowIn, LSB first, one bit per clock,
// through a single full-subtractor cell with a registered borrow chain.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrowOut
);

    localparam int             CW       = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic             w_cell_d;
    logic             w_cell_bout;

    full_subtractor u_cell (
        .a          (r_a[0]),
        .b          (r_b[0]),
        .borrowIn   (r_borrow),
        .difference (w_cell_d),
        .borrowOut  (w_cell_bout)
    );

    // NOTE: every output of always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (r_count == LAST_BIT) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= borrowIn;
                        r_count  <= '0;
                    end
                end
                ST_RUN: begin
                    // Result fills from the MSB end; the cast also keeps WIDTH=1 legal.
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_diff   <= WIDTH'({w_cell_d, r_diff} >> 1);
                    r_borrow <= w_cell_bout;
                    r_count  <= r_count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign difference = r_diff;
    assign borrowOut  = r_borrow;

endmodule
